// File: rtl/memo_accum_sink_if.sv
// Bundles the memo_accum_sink beat input and frame-result output channels.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready carry valid-ready flow control in each direction.
// Signals:
//   in_valid / in_ready / in_struct[5:0] / in_matrix[1:0][3:0] / in_last : beat stream
//   out_valid / out_ready / out_sum / out_count / out_ovf                : frame result
// Modports: slave = the sink block, master = the producer/consumer driving it.
interface memo_accum_sink_if #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [5:0]              in_struct;
    logic [1:0][3:0]         in_matrix;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0]        out_count;
    logic                    out_ovf;

    modport slave (
        input  in_valid, in_struct, in_matrix, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport master (
        output in_valid, in_struct, in_matrix, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/memo_accum_sink.sv
// Buffers memo beats in a small FIFO and reduces each frame to a signed sum with count and sticky overflow.
// Latency: last beat pushed at edge N shows out_valid after edge N+1; one pop per cycle while accumulating.
// Backpressure: in_ready = FIFO not full; a held result (out_ready low) stops popping so the FIFO fills.
// Ports: clk, rst (async active-high), bus (memo_accum_sink_if.slave) carrying the beat input and result output.
module memo_accum_sink #(
    parameter int DEPTH     = 4,
    parameter int ACC_W     = 12,
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    memo_accum_sink_if.slave bus
);
    typedef struct packed {
        logic [3:0]        parts_hi;
        logic signed [1:0] parts_lo;
    } memo_struct_t;

    typedef struct packed {
        memo_struct_t    s;
        logic [1:0][3:0] m;
        logic            last;
    } beat_t;

    typedef enum logic {
        ST_ACCUM,
        ST_EMIT
    } state_t;

    localparam int AW = $clog2(DEPTH);

    // FIFO storage and pointers; the extra pointer MSB separates full from empty.
    beat_t           mem_q [DEPTH];
    beat_t           mem_d [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;

    state_t          state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    beat_t            head;
    beat_t            wr_beat;
    logic signed [6:0] beat_val;
    logic [ACC_W-1:0] val_ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             close;

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign push    = bus.in_valid && !full;
    assign pop     = (state_q == ST_ACCUM) && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_beat = {bus.in_struct, bus.in_matrix, bus.in_last};

    // Beat value spans -2..46, so 7 signed bits hold it exactly.
    assign beat_val = $signed({3'b000, head.s.parts_hi})
                    + $signed({{5{head.s.parts_lo[1]}}, head.s.parts_lo})
                    + $signed({3'b000, head.m[0]})
                    + $signed({3'b000, head.m[1]});
    assign val_ext  = {{(ACC_W-7){beat_val[6]}}, beat_val};
    assign sum      = acc_q + val_ext;
    // Two's-complement overflow: operands agree in sign but the result does not.
    assign add_ovf  = (acc_q[ACC_W-1] == val_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign close    = head.last || (cnt_inc == CNT_W'(MAX_BEATS));

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_beat;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end

        case (state_q)
            ST_ACCUM: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    acc_d    = sum;
                    cnt_d    = cnt_inc;
                    ovf_d    = ovf_q | add_ovf;
                    if (close) begin
                        out_sum_d   = sum;
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_q | add_ovf;
                        state_d     = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                // Result registers stay frozen; only the running frame state is cleared.
                if (bus.out_ready) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = (state_q == ST_EMIT);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
